// File: rtl/tdm_rx_deser.sv
// ST-BUS TDM receive deserializer: f0 frame alignment, HUNT/CHECK/LOCK
// sync tracking and MSB-first byte assembly per timeslot.
module tdm_rx_deser #(
  parameter int NSLOT     = 32,
  parameter int FRAME_LEN = 512,
  parameter int LOCK_CNT  = 2
) (
  input  logic       c4,
  input  logic       rst_n,
  input  logic       f0,
  input  logic       clk_en_rx,
  input  logic       rx_data,
  output logic [7:0] slot_data,
  output logic [4:0] slot_num,
  output logic       slot_valid,
  output logic       frame_start,
  output logic       sync_ok,
  output logic       sync_err
);

  localparam int SW = $clog2(NSLOT);
  localparam int BW = SW + 3;
  localparam int CW = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {
    HUNT,
    CHECK,
    LOCK
  } state_t;

  logic [1:0]    rsync_q;
  logic          rst_ni;
  state_t        state_q, state_d;
  logic [2:0]    good_q, good_d;
  logic [CW-1:0] per_q, per_d;
  logic          f0_q;
  logic          act_q;
  logic [BW-1:0] bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    slot_data_q, slot_data_d;
  logic [4:0]    slot_num_q, slot_num_d;
  logic          slot_valid_q, vld_d;
  logic          frame_start_q;
  logic          sync_ok_q;
  logic          sync_err_q, err_d;
  logic          f0_edge, good, early, miss, stb, done;

  // Assert asynchronously, release on the second c4 edge.
  always_ff @(posedge c4 or negedge rst_n) begin
    if (!rst_n) rsync_q <= '0;
    else        rsync_q <= {rsync_q[0], 1'b1};
  end

  assign rst_ni = rsync_q[1];

  assign f0_edge = f0_q & ~f0;
  assign good    = f0_edge && (per_q == CW'(FRAME_LEN - 1));
  assign early   = f0_edge && (per_q < CW'(FRAME_LEN - 1));
  assign miss    = !f0_edge && (per_q == CW'(FRAME_LEN - 1));

  always_comb begin
    per_d = per_q;
    if (f0_edge)                     per_d = '0;
    else if (per_q != CW'(FRAME_LEN)) per_d = per_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_d   = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (f0_edge) begin
          state_d = CHECK;
          good_d  = '0;
        end
      end
      CHECK: begin
        if (good) begin
          if (good_q + 3'd1 == 3'(LOCK_CNT)) begin
            state_d = LOCK;
            good_d  = 3'(LOCK_CNT);
          end else begin
            good_d = good_q + 3'd1;
          end
        end else if (early) begin
          good_d = '0;
        end else if (miss) begin
          state_d = HUNT;
        end
      end
      LOCK: begin
        if (early || miss) begin
          state_d = HUNT;
          err_d   = 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // A strobe coincident with the edge still closes the old frame.
  assign stb  = clk_en_rx & act_q;
  assign done = stb && (bit_q[2:0] == 3'b111);

  always_comb begin
    sh_d        = stb ? {sh_q[6:0], rx_data} : sh_q;
    bit_d       = bit_q;
    if (f0_edge)  bit_d = '0;
    else if (stb) bit_d = bit_q + 1'b1;
    vld_d       = done && sync_ok_q;
    slot_data_d = vld_d ? sh_d : slot_data_q;
    slot_num_d  = vld_d ? 5'(bit_q[BW-1:3]) : slot_num_q;
  end

  always_ff @(posedge c4 or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= HUNT;
      good_q        <= '0;
      per_q         <= '0;
      f0_q          <= 1'b1;
      act_q         <= 1'b0;
      bit_q         <= '0;
      sh_q          <= '0;
      slot_data_q   <= '0;
      slot_num_q    <= '0;
      slot_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      sync_ok_q     <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      good_q        <= good_d;
      per_q         <= per_d;
      f0_q          <= f0;
      act_q         <= act_q | f0_edge;
      bit_q         <= bit_d;
      sh_q          <= sh_d;
      slot_data_q   <= slot_data_d;
      slot_num_q    <= slot_num_d;
      slot_valid_q  <= vld_d;
      frame_start_q <= f0_edge;
      sync_ok_q     <= (state_d == LOCK);
      sync_err_q    <= err_d;
    end
  end

  assign slot_data   = slot_data_q;
  assign slot_num    = slot_num_q;
  assign slot_valid  = slot_valid_q;
  assign frame_start = frame_start_q;
  assign sync_ok     = sync_ok_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_rx_deser.sv
// Bench for tdm_rx_deser: per-frame table of f0/strobe patterns with
// expected sync/pulse counts, plus a byte scoreboard fed by the driver.
module tb_tdm_rx_deser;

  logic       c4 = 1'b0;
  logic       rst_n = 1'b1;
  logic       f0 = 1'b1;
  logic       clk_en_rx = 1'b0;
  logic       rx_data = 1'b0;
  logic [7:0] slot_data;
  logic [4:0] slot_num;
  logic       slot_valid;
  logic       frame_start;
  logic       sync_ok;
  logic       sync_err;

  tdm_rx_deser dut (
    .c4(c4),
    .rst_n(rst_n),
    .f0(f0),
    .clk_en_rx(clk_en_rx),
    .rx_data(rx_data),
    .slot_data(slot_data),
    .slot_num(slot_num),
    .slot_valid(slot_valid),
    .frame_start(frame_start),
    .sync_ok(sync_ok),
    .sync_err(sync_err)
  );

  always #5 c4 = ~c4;

  typedef struct {
    int len;
    bit pulse;
    int low;
    bit ph;
    bit lk;
    bit ok;
    int err;
    int fs;
    int nv;
  } vec_t;

  typedef struct {
    logic [4:0] num;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       me;
  vec_t       tbl[19];
  int         total = 0;
  int         bad = 0;
  int         n_v = 0;
  int         n_err = 0;
  int         n_fs = 0;
  int         bidx = 0;
  bit         act = 1'b0;
  bit         lk_prev = 1'b0;
  logic [7:0] sh = 8'h00;
  logic [7:0] pa5 = 8'hA5;
  logic [7:0] p3c = 8'h3C;

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  always @(posedge c4) begin
    #1;
    if (slot_valid) begin
      n_v++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious slot_valid: num=%0d data=%0h want none",
                 slot_num, slot_data);
      end else begin
        me = exp_q.pop_front();
        chk("slot_num", int'(slot_num), int'(me.num));
        chk("slot_data", int'(slot_data), int'(me.data));
      end
    end
    if (sync_err) n_err++;
    if (frame_start) n_fs++;
  end

  task automatic cyc(input logic f, input logic e, input logic d);
    f0 = f;
    clk_en_rx = e;
    rx_data = d;
    @(posedge c4);
    #2;
  endtask

  task automatic set(input int i, input int len, input bit p,
                     input int low, input bit ph, input bit lk,
                     input bit ok, input int err, input int fs,
                     input int nv);
    tbl[i] = '{len, p, low, ph, lk, ok, err, fs, nv};
  endtask

  task automatic frame(input int idx);
    vec_t v;
    logic f, e, d;
    int   b;
    exp_t ev;
    v = tbl[idx];
    n_v = 0;
    n_err = 0;
    n_fs = 0;
    for (int k = 0; k < v.len; k++) begin
      f = (v.pulse && k < v.low) ? 1'b0 : 1'b1;
      e = ((k % 2) == int'(v.ph));
      b = 7 - (bidx % 8);
      if (bidx / 8 == 5)       d = pa5[b];
      else if (bidx / 8 == 31) d = p3c[b];
      else                     d = 1'($urandom_range(0, 1));
      if (e && act) begin
        sh = {sh[6:0], d};
        if (bidx % 8 == 7 && (k == 0 ? lk_prev : v.lk)) begin
          ev.num = 5'(bidx / 8);
          ev.data = sh;
          exp_q.push_back(ev);
        end
        bidx = (bidx + 1) % 256;
      end
      if (k == 0 && v.pulse) begin
        bidx = 0;
        act = 1'b1;
      end
      cyc(f, e, d);
    end
    lk_prev = v.lk;
    chk($sformatf("row%0d sync_ok", idx), int'(sync_ok), int'(v.ok));
    chk($sformatf("row%0d sync_err", idx), n_err, v.err);
    chk($sformatf("row%0d frame_start", idx), n_fs, v.fs);
    chk($sformatf("row%0d slot_valid", idx), n_v, v.nv);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " slot_data"}, int'(slot_data), 0);
    chk({tag, " slot_num"}, int'(slot_num), 0);
    chk({tag, " slot_valid"}, int'(slot_valid), 0);
    chk({tag, " frame_start"}, int'(frame_start), 0);
    chk({tag, " sync_ok"}, int'(sync_ok), 0);
    chk({tag, " sync_err"}, int'(sync_err), 0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      cyc(1'b1, 1'(k % 2), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    //      len  p low ph lk ok err fs nv
    set(0,  512, 1, 1, 1, 0, 0, 0, 1, 0);
    set(1,  512, 1, 1, 1, 0, 0, 0, 1, 0);
    set(2,  512, 1, 1, 1, 1, 1, 0, 1, 32);
    set(3,  512, 1, 1, 1, 1, 1, 0, 1, 32);
    set(4,  512, 0, 0, 1, 0, 0, 1, 0, 0);
    set(5,  512, 1, 1, 1, 0, 0, 0, 1, 0);
    set(6,  512, 1, 1, 1, 0, 0, 0, 1, 0);
    set(7,  512, 1, 1, 1, 1, 1, 0, 1, 32);
    set(8,  301, 1, 1, 1, 1, 1, 0, 1, 18);
    set(9,  512, 1, 1, 1, 0, 0, 1, 1, 0);
    set(10, 512, 1, 1, 1, 0, 0, 0, 1, 0);
    set(11, 512, 1, 1, 1, 0, 0, 0, 1, 0);
    set(12, 512, 1, 1, 1, 1, 1, 0, 1, 32);
    set(13, 512, 1, 3, 0, 1, 1, 0, 1, 31);
    set(14, 512, 1, 3, 0, 1, 1, 0, 1, 32);
    set(15, 100, 1, 1, 1, 1, 1, 0, 1, 6);
    set(16, 512, 1, 1, 1, 0, 0, 0, 1, 0);
    set(17, 512, 1, 1, 1, 0, 0, 0, 1, 0);
    set(18, 512, 1, 1, 1, 1, 1, 0, 1, 32);

    #1 rst_n = 1'b0;
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    check_reset_vals("por");
    rst_n = 1'b1;
    idle(20);
    chk("pre-edge slot_valid", n_v, 0);

    for (int i = 0; i <= 15; i++) frame(i);

    chk("pre-reset slot_num", int'(slot_num), 5);
    chk("pre-reset slot_data", int'(slot_data), 8'hA5);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midbyte");
    chk("pending at reset", exp_q.size(), 0);
    exp_q.delete();
    act = 1'b0;
    bidx = 0;
    lk_prev = 1'b0;
    sh = 8'h00;
    repeat (3) cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)));
    rst_n = 1'b1;
    n_v = 0;
    idle(20);
    chk("post-reset sync_ok", int'(sync_ok), 0);
    chk("post-reset slot_valid", n_v, 0);

    for (int i = 16; i <= 18; i++) frame(i);

    repeat (2) cyc(1'b1, 1'b0, 1'b0);
    chk("scoreboard drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
